dcache_refill_ctrl: RTL

Miss-handling controller for the 2-way set-associative data cache. On a miss it picks the victim way, writes back the victim line if it is dirty, then issues a burst read and streams the returned words into the data RAM. It sits directly downstream of the cache's 5-bit replacement LFSR and consumes that LFSR's `way_to_replace` bit whenever both ways of the set are valid.

---
 rtl/dcache_refill_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dcache_refill_ctrl.sv
// Miss-handling controller for the 2-way set-associative data cache: selects a victim,
// writes it back when dirty, then requests a burst refill and streams it into the data RAM.
module dcache_refill_ctrl #(
  parameter int TAG_W      = 20,
  parameter int IDX_W      = 8,
  parameter int LINE_WORDS = 4,
  localparam int WORD_W    = $clog2(LINE_WORDS),
  localparam int LINE_W    = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              miss_req,
  input  logic [31:0]       miss_addr,
  input  logic              way0_valid,
  input  logic              way1_valid,
  input  logic              way0_dirty,
  input  logic              way1_dirty,
  input  logic [TAG_W-1:0]  way0_tag,
  input  logic [TAG_W-1:0]  way1_tag,
  input  logic [LINE_W-1:0] way0_line,
  input  logic [LINE_W-1:0] way1_line,
  input  logic              lfsr_way,
  output logic              busy,
  output logic              wr_req,
  output logic [31:0]       wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy,
  output logic              rd_req,
  output logic [31:0]       rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [31:0]       ret_data,
  output logic              refill_we,
  output logic              refill_way,
  output logic [IDX_W-1:0]  refill_index,
  output logic [WORD_W-1:0] refill_word,
  output logic [31:0]       refill_data,
  output logic [TAG_W-1:0]  refill_tag,
  output logic              done,
  output logic [2:0]        fsm_state
);

  // Handshake: wr_req/rd_req stay high with stable address/data until the cycle
  // in which the matching *_rdy is sampled high; ret_valid beats need no ready.

  localparam int OFF_W = 32 - TAG_W - IDX_W;
  localparam int CNT_W = WORD_W + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  index_q;
  logic [TAG_W-1:0]  victim_tag_q;
  logic [LINE_W-1:0] victim_line_q;
  logic              victim_way_q;
  logic [CNT_W-1:0]  beat_cnt;

  logic              victim_way;
  logic              victim_valid;
  logic              victim_dirty;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

  // Prefer an empty way; only consult the LFSR when the set is full.
  always_comb begin
    victim_way = 1'b0;
    if (!way0_valid)      victim_way = 1'b0;
    else if (!way1_valid) victim_way = 1'b1;
    else                  victim_way = lfsr_way;
    victim_valid = victim_way ? way1_valid : way0_valid;
    victim_dirty = victim_way ? way1_dirty : way0_dirty;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (miss_req) state_next = (victim_valid && victim_dirty) ? WB_REQ : RD_REQ;
      WB_REQ:  if (wr_rdy) state_next = RD_REQ;
      RD_REQ:  if (rd_rdy) state_next = RD_WAIT;
      RD_WAIT: if (ret_valid && ret_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign wr_req    = (state == WB_REQ);
  assign rd_req    = (state == RD_REQ);
  assign wr_addr   = wr_req ? {victim_tag_q, index_q, {OFF_W{1'b0}}} : 32'd0;
  assign wr_data   = wr_req ? victim_line_q : '0;
  assign rd_addr   = rd_req ? {miss_tag_q, index_q, {OFF_W{1'b0}}} : 32'd0;
  assign fsm_state = state;

  assign refill_way   = victim_way_q;
  assign refill_index = index_q;
  assign refill_tag   = miss_tag_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miss_tag_q    <= '0;
      index_q       <= '0;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      victim_way_q  <= 1'b0;
      beat_cnt      <= '0;
      refill_we     <= 1'b0;
      refill_word   <= '0;
      refill_data   <= '0;
      done          <= 1'b0;
    end else begin
      refill_we <= 1'b0;
      done      <= 1'b0;

      if (state == IDLE && miss_req) begin
        miss_tag_q    <= miss_addr[31 -: TAG_W];
        index_q       <= miss_addr[OFF_W +: IDX_W];
        victim_way_q  <= victim_way;
        victim_tag_q  <= victim_way ? way1_tag : way0_tag;
        victim_line_q <= victim_way ? way1_line : way0_line;
        beat_cnt      <= '0;
      end

      if (state == RD_REQ) beat_cnt <= '0;

      // Beats past the end of the line are dropped; the counter parks at the limit.
      if (state == RD_WAIT && ret_valid) begin
        if (beat_cnt < CNT_LIMIT) begin
          refill_we   <= 1'b1;
          refill_word <= beat_cnt[WORD_W-1:0];
          refill_data <= ret_data;
          beat_cnt    <= beat_cnt + CNT_W'(1);
        end
        if (ret_last) done <= 1'b1;
      end
    end
  end

endmodule
